// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared types and constants for the serial frame receiver.
//   state_e        - receiver FSM states
//   DATA_W_DEFAULT - default data bits per frame
//   IDLE_LEVEL     - level of the idle serial line (and of the stop bit)
package serial_frame_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam logic        IDLE_LEVEL     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: multi-flop synchronizer for an asynchronous single-bit input.
// Every stage resets to the idle line level so no false start bit is seen
// while coming out of reset.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (last stage)
module sync_ff_chain
    import serial_frame_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receiver for start/data/[parity]/stop frames sampled one
// bit per clock, with a single-word holding register and valid/ready output.
// Optional feature: define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit
// after the data bits; otherwise parity_err is tied 0.
//   clk        - clock
//   rst        - asynchronous active-low reset
//   sin        - asynchronous serial line, idles high
//   dout       - received word, LSB first on the line
//   dout_valid - dout holds an unconsumed word
//   dout_ready - consumer accepts dout when dout_valid is also high
//   frame_err  - one-cycle pulse, stop bit sampled low
//   parity_err - one-cycle pulse, parity mismatch
//   overrun    - one-cycle pulse, good frame dropped because dout was full
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned          CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);

    logic s_bit;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (sin),
        .q_o    (s_bit)
    );

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              parity_bad;
    logic              accept;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_q;
    logic parity_err_q;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_bad = ^{shift_q, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    assign accept = dout_valid_q & dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (accept) begin
                dout_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (s_bit != IDLE_LEVEL) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end
                DATA: begin
                    // Right shift so the first bit received ends up in bit 0.
                    shift_q <= {s_bit, shift_q[DATA_W-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    par_q   <= s_bit;
                    state_q <= STOP;
                end
`endif
                STOP: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    parity_err_q <= parity_bad;
`endif
                    if (s_bit == IDLE_LEVEL) begin
                        state_q <= IDLE;
                        if (!parity_bad) begin
                            // An accept in this same cycle frees the register,
                            // so the new word replaces the old without overrun.
                            if (!dout_valid_q || accept) begin
                                dout_q       <= shift_q;
                                dout_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                    end
                end
                BREAK: begin
                    if (s_bit == IDLE_LEVEL) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: self-checking bench for serial_frame_rx (DATA_W=8,
// SYNC_STAGES=2). Frames are described at the word level; the bench schedules
// each frame's outcome at a fixed latency after its stop bit and a small
// holding-register model turns those outcomes plus the ready history into the
// expected outputs for every cycle.
`timescale 1ns/1ps
module tb_serial_frame_rx;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int LAT  = S + 1;
    localparam int MAXC = 8192;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // Outcome codes for a completed frame.
    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_FERR = 2;
    localparam int EV_PERR = 3;
    localparam int EV_BOTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b1;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    serial_frame_rx #(
        .DATA_W      (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rst_lvl = 1'b0;
    bit          rdy_rand = 1'b0;
    logic        rdy_fixed = 1'b1;

    bit           rdy_hist [MAXC];
    bit           rst_hist [MAXC];
    int           ev_kind  [MAXC];
    logic [W-1:0] ev_word  [MAXC];
    logic [W-1:0] obs_d    [MAXC];
    bit           obs_v    [MAXC];
    bit           obs_fe   [MAXC];
    bit           obs_pe   [MAXC];
    bit           obs_ov   [MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs 1ns after the rising edge.
    task automatic tick(input logic b, input logic r);
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_lvl;
        sin = b;
        dout_ready = r;
        rst_hist[cyc] = rst_lvl;
        rdy_hist[cyc] = r;
    endtask

    function automatic logic pick_rdy();
        if (rdy_rand) return ($urandom_range(0, 1) == 1);
        return rdy_fixed;
    endfunction

    task automatic send_frame(input logic [W-1:0] d, input bit bad_stop, input bit bad_par,
                              output int unsigned stop_cyc);
        logic p;
        int   kind;
        tick(1'b0, pick_rdy());
        for (int i = 0; i < W; i++) tick(d[i], pick_rdy());
        if (PAR) begin
            p = (^d) ^ bad_par;
            tick(p, pick_rdy());
        end
        tick(!bad_stop, pick_rdy());
        stop_cyc = cyc;
        if (bad_stop && bad_par && PAR) kind = EV_BOTH;
        else if (bad_stop)              kind = EV_FERR;
        else if (bad_par && PAR)        kind = EV_PERR;
        else                            kind = EV_GOOD;
        ev_kind[cyc + LAT] = kind;
        ev_word[cyc + LAT] = d;
    endtask

    // Holding-register model, evaluated every cycle on the falling edge.
    bit           mv = 1'b0;
    logic [W-1:0] md = '0;

    always @(negedge clk) begin
        bit v0;
        bit acc;
        bit mfe;
        bit mpe;
        bit mov;
        if (cyc >= 1 && cyc < MAXC) begin
            mfe = 1'b0;
            mpe = 1'b0;
            mov = 1'b0;
            if (!rst_hist[cyc] || !rst_hist[cyc-1]) begin
                mv = 1'b0;
                md = '0;
            end else begin
                v0  = mv;
                acc = v0 && rdy_hist[cyc-1];
                if (acc) mv = 1'b0;
                if (ev_kind[cyc] == EV_GOOD) begin
                    if (!v0 || acc) begin
                        mv = 1'b1;
                        md = ev_word[cyc];
                    end else begin
                        mov = 1'b1;
                    end
                end
                mfe = (ev_kind[cyc] == EV_FERR) || (ev_kind[cyc] == EV_BOTH);
                mpe = (ev_kind[cyc] == EV_PERR) || (ev_kind[cyc] == EV_BOTH);
            end
            chk("dout", dout, md);
            chk("dout_valid", dout_valid, mv);
            chk("frame_err", frame_err, mfe);
            chk("parity_err", parity_err, mpe);
            chk("overrun", overrun, mov);
            obs_d[cyc]  = dout;
            obs_v[cyc]  = dout_valid;
            obs_fe[cyc] = frame_err;
            obs_pe[cyc] = parity_err;
            obs_ov[cyc] = overrun;
        end
    end

    initial begin
        int unsigned n;
        int unsigned m;
        int unsigned c;
        bit          all_ok;
        logic [W-1:0] rd;
        bit          bs;
        bit          bp;

        // Reset state.
        rst_lvl = 1'b0;
        repeat (3) tick(1'b1, 1'b1);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        rst_lvl = 1'b1;
        repeat (3) tick(1'b1, 1'b1);

        // 0xA5 with ready high: valid for exactly one cycle, LAT after stop.
        rdy_fixed = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, n);
        repeat (6) tick(1'b1, 1'b1);
        chk("a5_early", obs_v[n+2], 0);
        chk("a5_valid", obs_v[n+3], 1);
        chk("a5_data", obs_d[n+3], 8'hA5);
        chk("a5_fall", obs_v[n+4], 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(8'h3C, 1'b0, 1'b0, n);
        repeat (3) tick(1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, m);
        repeat (6) tick(1'b1, 1'b1);
        chk("par_ok_data", obs_d[n+3], 8'h3C);
        chk("par_ok_valid", obs_v[n+3], 1);
        chk("par_bad_pulse", obs_pe[m+3], 1);
        chk("par_bad_valid", obs_v[m+3], 0);
`endif

        // Bad stop on 0x55, line held low, then recovery and 0x0F.
        send_frame(8'h55, 1'b1, 1'b0, n);
        repeat (5) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b0, m);
        repeat (5) tick(1'b1, 1'b1);
        chk("ferr_pulse", obs_fe[n+3], 1);
        chk("ferr_novalid", obs_v[n+3], 0);
        chk("after_break_data", obs_d[m+3], 8'h0F);
        chk("after_break_valid", obs_v[m+3], 1);

        // Overrun: 0x11 then 0x22 back-to-back with ready low.
        rdy_fixed = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, n);
        send_frame(8'h22, 1'b0, 1'b0, m);
        repeat (4) tick(1'b1, 1'b0);
        chk("ovr_first_none", obs_ov[n+3], 0);
        chk("ovr_pulse", obs_ov[m+3], 1);
        chk("ovr_kept", obs_d[m+3], 8'h11);
        tick(1'b1, 1'b1);
        c = cyc;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("ovr_held_valid", obs_v[c], 1);
        chk("ovr_accept_fall", obs_v[c+1], 0);

        // Accept 0x01 in the same cycle 0x02 loads.
        send_frame(8'h01, 1'b0, 1'b0, n);
        send_frame(8'h02, 1'b0, 1'b0, m);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b1, 1'b0);
        chk("swap_prev", obs_d[m+2], 8'h01);
        chk("swap_data", obs_d[m+3], 8'h02);
        chk("swap_no_ovr", obs_ov[m+3], 0);
        all_ok = 1'b1;
        for (int unsigned k = n + 3; k <= m + 5; k++) if (!obs_v[k]) all_ok = 1'b0;
        chk("swap_valid_steady", all_ok, 1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        // Reset in the middle of 0xFF's data bits, then 0x81.
        rdy_fixed = 1'b1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        rst_lvl = 1'b0;
        tick(1'b1, 1'b1);
        c = cyc;
        repeat (2) tick(1'b1, 1'b1);
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        rst_lvl = 1'b1;
        repeat (4) tick(1'b1, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, n);
        repeat (5) tick(1'b1, 1'b1);
        chk("postrst_data", obs_d[n+3], 8'h81);
        chk("postrst_valid", obs_v[n+3], 1);
        all_ok = 1'b1;
        for (int unsigned k = c; k <= n + 5; k++)
            if (obs_fe[k] || obs_pe[k] || obs_ov[k]) all_ok = 1'b0;
        chk("postrst_no_err", all_ok, 1);

        // Randomized frames, gaps, bad stops/parity and ready.
        rdy_rand = 1'b1;
        for (int f = 0; f < 60; f++) begin
            rd = W'($urandom);
            bs = ($urandom_range(0, 7) == 0);
            bp = PAR && ($urandom_range(0, 7) == 0);
            send_frame(rd, bs, bp, n);
            if (bs) begin
                repeat ($urandom_range(0, 4)) tick(1'b0, pick_rdy());
                tick(1'b1, pick_rdy());
            end else begin
                repeat ($urandom_range(0, 3)) tick(1'b1, pick_rdy());
            end
        end
        rdy_rand = 1'b0;
        repeat (10) tick(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
